elevator_sched: RTL
===================

Name: elevator_sched

Overview:
- Parametrised successor to the combinational up/down passenger decoder.
- Generalised to FLOORS floors × SLOTS waiting-passenger slots per floor; derives correct up/down hall calls (dest < floor is down).
- Adds a registered car-call latch and a single-car motion/door state machine that chooses direction, moves floor by floor, stops and opens doors.
- Sits between the passenger-generation logic and the display/score logic.

Parameters:
- FLOORS, 7, number of floors, numbered 1..FLOORS.
- SLOTS, 2, waiting-passenger slots per floor.
- FW, 3, bits per floor code; must satisfy 2^FW > FLOORS.
- MOVE_CYCLES, 4, clock cycles to travel one floor (≥1).
- DOOR_CYCLES, 3, clock cycles the door stays open (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- remaining  in  FLOORS*SLOTS*FW  per-slot destination floor. Slot s of floor f is at bits [((f-1)*SLOTS+s)*FW +: FW]. Code 0 means empty.
- car_call  in  FLOORS  in-car button pulses; bit f-1 requests floor f.
- up_passenger  out  FLOORS*SLOTS  registered per-slot "wants up" flag, same slot order as remaining.
- down_passenger  out  FLOORS*SLOTS  registered per-slot "wants down" flag.
- cur_floor  out  FW  current car floor (1..FLOORS).
- dir  out  2  motion direction: 00 idle, 01 up, 10 down.
- door_open  out  1  high while the door is open.
- arrive  out  1  one-cycle pulse on entry to DOOR.

Behaviour:
- Reset values (async): up_passenger=0, down_passenger=0, cur_floor=1, dir=00, door_open=0, arrive=0, car_req=0, state=IDLE, timer=0.
- Slot decode:
  - Let d = slot code and f = slot's floor.
  - up = (d != 0) && (d ≤ FLOORS) && (d > f).
  - down = (d != 0) && (d ≤ FLOORS) && (d < f).
  - d == f, or d > FLOORS, is treated as empty.
  - Flags are registered: one-cycle latency from remaining.
- Per-floor calls:
  - hall_up[f] = OR of that floor's up flags; hall_dn[f] = OR of its down flags.
  - These use the registered flags.
- car_req[f]: set by car_call[f-1]; cleared on DOOR entry at floor f. If set and clear coincide at the same floor, clear wins.
- req[f] = car_req[f] | hall_up[f] | hall_dn[f]. req_above and req_below are the ORs of req over floors > and < cur_floor.
- Stop condition at cur_floor, any of:
  - car_req set, or
  - (dir up and hall_up), or
  - (dir down and hall_dn), or
  - req at cur_floor with no request further in the current direction.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE (dir=00):
  - req at cur_floor → DOOR.
  - Else req_above → MOVE_UP.
  - Else req_below → MOVE_DOWN.
  - Up wins ties.
- MOVE_UP (dir=01):
  - Timer counts MOVE_CYCLES cycles; on the last cycle, cur_floor += 1.
  - On the next cycle, evaluate the stop condition → DOOR.
  - Else req_above → restart timer and continue; else → IDLE.
- MOVE_DOWN (dir=10): symmetric, with cur_floor -= 1.
- DOOR:
  - On entry: arrive=1 for one cycle, car_req[cur_floor] cleared.
  - door_open=1 for exactly DOOR_CYCLES cycles.
  - dir holds the last motion direction; 00 if entered from IDLE.
  - On exit: continue the held direction if requests remain that way; else reverse if requests remain the other way; else IDLE.
- Boundaries:
  - cur_floor never leaves 1..FLOORS. MOVE_UP is never entered at FLOORS; MOVE_DOWN is never entered at 1.
  - A request appearing mid-travel is honoured at the next floor evaluation.
  - Requests vanishing mid-travel: finish the current floor step, then go IDLE.
  - car_call for the floor the door is currently open at is ignored (already served).
  - Reset asserted mid-move or mid-door returns immediately to reset values.

Test Plan:
- Reset, then remaining floor3 slot0=5, all else 0 → up_passenger bit4=1 one cycle later; car goes 1→3 (cur_floor=2 after 4 cycles, 3 after 8); arrive pulse; door_open for 3 cycles; dir=01.
- Decode check: floor4 slots {2,6}; floor5 slot {5}; floor2 slot {7} (code > FLOORS with FLOORS=6) → down bit6=1, up bit7=1; bits for the d==f and out-of-range slots both 0.
- Car at 4 in DOOR, car_call floors 6 and 2 pressed → serves 6 first (previous dir up), then reverses to 2; car_req bits cleared on each arrival.
- Car at 1 IDLE, simultaneous hall call at 1 and car_call 5 → DOOR at 1 first (no motion), then MOVE_UP to 5.
- Car moving up toward 6 with FLOORS=7; down call appears at 5, up call at 6 → passes 5 without stopping, stops at 6, then returns to 5.
- Assert reset two cycles into MOVE_UP at floor 3 → cur_floor=1, dir=00, door_open=0, all flags 0 immediately; resumes from IDLE after release.

Source files
------------

// File: rtl/elevator_sched_if.sv
// Bundle of the passenger/car-call inputs and the car status outputs of
// elevator_sched.
//   remaining      : per-slot destination floor codes (0 = empty)
//   car_call       : in-car button pulses, bit f-1 = floor f
//   up_passenger   : registered per-slot "wants up" flags
//   down_passenger : registered per-slot "wants down" flags
//   cur_floor      : current car floor (1..FLOORS)
//   dir            : 00 idle, 01 up, 10 down
//   door_open      : door is open
//   arrive         : one-cycle pulse when the door opens
// master = passenger/display side, slave = the scheduler.
interface elevator_sched_if #(
  parameter int FLOORS = 7,
  parameter int SLOTS  = 2,
  parameter int FW     = 3
);
  logic [FLOORS*SLOTS*FW-1:0] remaining;
  logic [FLOORS-1:0]          car_call;
  logic [FLOORS*SLOTS-1:0]    up_passenger;
  logic [FLOORS*SLOTS-1:0]    down_passenger;
  logic [FW-1:0]              cur_floor;
  logic [1:0]                 dir;
  logic                       door_open;
  logic                       arrive;

  modport master (
    output remaining, car_call,
    input  up_passenger, down_passenger, cur_floor, dir, door_open, arrive
  );

  modport slave (
    input  remaining, car_call,
    output up_passenger, down_passenger, cur_floor, dir, door_open, arrive
  );
endinterface

// File: rtl/elevator_sched.sv
// Single-car elevator scheduler: decodes waiting-passenger slots into
// registered up/down hall flags, latches car calls and runs the car
// motion/door state machine.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : elevator_sched_if slave (see interface for signal list)
//
// state     | meaning
// IDLE      | car parked, dir=00, waiting for any request
// MOVE_UP   | travelling up one floor per MOVE_CYCLES, dir=01
// MOVE_DOWN | travelling down one floor per MOVE_CYCLES, dir=10
// DOOR      | door open for DOOR_CYCLES, dir holds last motion
module elevator_sched #(
  parameter int FLOORS      = 7,
  parameter int SLOTS       = 2,
  parameter int FW          = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input logic             clk,
  input logic             reset,
  elevator_sched_if.slave bus
);

  localparam int NS   = FLOORS * SLOTS;
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic              step_done;   // floor just changed; this cycle evaluates it
  logic [FLOORS-1:0] car_req;
  logic [NS-1:0]     up_q, dn_q;
  logic [FW-1:0]     cur_floor_q;
  logic [1:0]        dir_q;
  logic              door_q, arrive_q;

  logic [NS-1:0]     up_next, dn_next;
  logic [FW-1:0]     code;
  logic [FLOORS-1:0] here_mask, above_mask, below_mask;
  logic [FLOORS-1:0] hall_up, hall_dn, req, calls_ok;
  logic req_here, req_above, req_below, car_here, up_here, dn_here;
  logic stop_up, stop_dn, enter_door, exit_up;

  assign bus.up_passenger   = up_q;
  assign bus.down_passenger = dn_q;
  assign bus.cur_floor      = cur_floor_q;
  assign bus.dir            = dir_q;
  assign bus.door_open      = door_q;
  assign bus.arrive         = arrive_q;

  // Codes equal to the slot's own floor or beyond the top floor are empty.
  always_comb begin
    up_next = '0;
    dn_next = '0;
    code    = '0;
    for (int f = 1; f <= FLOORS; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        code = bus.remaining[((f-1)*SLOTS+s)*FW +: FW];
        if (code != '0 && int'(code) <= FLOORS) begin
          up_next[(f-1)*SLOTS+s] = int'(code) > f;
          dn_next[(f-1)*SLOTS+s] = int'(code) < f;
        end
      end
    end
  end

  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    hall_up    = '0;
    hall_dn    = '0;
    for (int f = 1; f <= FLOORS; f++) begin
      here_mask[f-1]  = int'(cur_floor_q) == f;
      above_mask[f-1] = int'(cur_floor_q) < f;
      below_mask[f-1] = int'(cur_floor_q) > f;
      hall_up[f-1]    = |up_q[(f-1)*SLOTS +: SLOTS];
      hall_dn[f-1]    = |dn_q[(f-1)*SLOTS +: SLOTS];
    end
  end

  assign req       = car_req | hall_up | hall_dn;
  assign req_here  = |(req & here_mask);
  assign req_above = |(req & above_mask);
  assign req_below = |(req & below_mask);
  assign car_here  = |(car_req & here_mask);
  assign up_here   = |(hall_up & here_mask);
  assign dn_here   = |(hall_dn & here_mask);

  // Stop for riders, same-direction hall calls, or the last request this way.
  assign stop_up = car_here | up_here | (req_here & ~req_above);
  assign stop_dn = car_here | dn_here | (req_here & ~req_below);

  assign enter_door = (state == IDLE && req_here) ||
                      (state == MOVE_UP && step_done && stop_up) ||
                      (state == MOVE_DOWN && step_done && stop_dn);

  // A press for the floor whose door is open is already served.
  assign calls_ok = bus.car_call & ~((state == DOOR) ? here_mask : '0);

  // Leaving the door: keep going down only if last motion was down and work
  // remains below; otherwise prefer up.
  assign exit_up = req_above & ~((dir_q == 2'b10) & req_below);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      step_done   <= 1'b0;
      car_req     <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      cur_floor_q <= FW'(1);
      dir_q       <= 2'b00;
      door_q      <= 1'b0;
      arrive_q    <= 1'b0;
    end else begin
      up_q     <= up_next;
      dn_q     <= dn_next;
      arrive_q <= 1'b0;
      car_req  <= car_req | calls_ok;
      if (enter_door) begin
        state     <= DOOR;
        timer     <= DOOR_LOAD;
        door_q    <= 1'b1;
        arrive_q  <= 1'b1;
        step_done <= 1'b0;
        car_req   <= (car_req | calls_ok) & ~here_mask;
      end else begin
        case (state)
          IDLE: begin
            timer     <= MOVE_LOAD;
            step_done <= 1'b0;
            if (req_above) begin
              state <= MOVE_UP;
              dir_q <= 2'b01;
            end else if (req_below) begin
              state <= MOVE_DOWN;
              dir_q <= 2'b10;
            end else begin
              dir_q <= 2'b00;
            end
          end
          MOVE_UP, MOVE_DOWN: begin
            if (step_done && !((state == MOVE_UP) ? req_above : req_below)) begin
              state     <= IDLE;
              dir_q     <= 2'b00;
              step_done <= 1'b0;
            end else if (timer == '0) begin
              cur_floor_q <= (state == MOVE_UP) ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;
              timer       <= MOVE_LOAD;
              step_done   <= 1'b1;
            end else begin
              timer     <= timer - 1'b1;
              step_done <= 1'b0;
            end
          end
          DOOR: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              door_q    <= 1'b0;
              timer     <= MOVE_LOAD;
              step_done <= 1'b0;
              if (exit_up) begin
                state <= MOVE_UP;
                dir_q <= 2'b01;
              end else if (req_below) begin
                state <= MOVE_DOWN;
                dir_q <= 2'b10;
              end else begin
                state <= IDLE;
                dir_q <= 2'b00;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
